rect_layer_ctrl: RTL and testbench

// - Frame-synchronous scheduler for the rectangle overlay datapath behind the vga timing block.
// - Holds NRECT rectangle descriptors in a shadow table that software/FSM writes at any time.
// - Copies the shadow table to the active table only at vertical-blank start, so frames never tear.
// - Resolves overlap per pixel by fixed priority (lowest index wins) and drives RED/GREEN/BLUE.

---
 rtl/rect_layer_ctrl_if.sv | 26 ++
 rtl/rect_layer_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_rect_layer_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_layer_ctrl_if.sv
// Descriptor-write / commit interface for rect_layer_ctrl.
// Handshake: a write transfers on any rising clk edge where wr_valid & wr_ready
// are both high; the master holds wr_idx/wr_field/wr_data stable while wr_valid
// is high and wr_ready is low. commit is a one-cycle pulse and needs no ready.
interface rect_layer_ctrl_if #(
  parameter int IDXW = 2
);
  logic            wr_valid;
  logic            wr_ready;
  logic [IDXW-1:0] wr_idx;
  logic [2:0]      wr_field;
  logic [11:0]     wr_data;
  logic            commit;
  logic            busy;
  logic            frame_done;

  modport master (
    output wr_valid, wr_idx, wr_field, wr_data, commit,
    input  wr_ready, busy, frame_done
  );

  modport slave (
    input  wr_valid, wr_idx, wr_field, wr_data, commit,
    output wr_ready, busy, frame_done
  );
endinterface

// File: rtl/rect_layer_ctrl.sv
// Frame-synchronous rectangle overlay scheduler.
// Software writes descriptors into a shadow table; a commit publishes the
// shadow table into the active table at the next vertical-blank start so a
// frame never tears. The pixel path reads only the active table, resolves
// overlap by lowest index and outputs RGB two clocks after x/y.
// Optional feature macro: RECT_OUTLINE_EN (ctrl[1] selects 1-pixel outline).
module rect_layer_ctrl #(
  parameter int          NRECT    = 4,
  parameter int          IDXW     = 2,
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  rect_layer_ctrl_if.slave  wr_if,
  output logic [3:0]        RED,
  output logic [3:0]        GREEN,
  output logic [3:0]        BLUE,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_COPY = 2'd2
  } state_t;

  localparam logic [9:0]      HA     = 10'(H_ACTIVE);
  localparam logic [9:0]      VA     = 10'(V_ACTIVE);
  localparam logic [IDXW-1:0] LAST   = IDXW'(NRECT - 1);
  localparam logic [IDXW:0]   NREC_W = (IDXW + 1)'(NRECT);

  // Shadow table (software-visible) and active table (pixel path)
  logic [9:0]  r_sh_x0  [NRECT];
  logic [9:0]  r_sh_x1  [NRECT];
  logic [9:0]  r_sh_y0  [NRECT];
  logic [9:0]  r_sh_y1  [NRECT];
  logic [11:0] r_sh_col [NRECT];
  logic [1:0]  r_sh_ctl [NRECT];
  logic [9:0]  r_ac_x0  [NRECT];
  logic [9:0]  r_ac_x1  [NRECT];
  logic [9:0]  r_ac_y0  [NRECT];
  logic [9:0]  r_ac_y1  [NRECT];
  logic [11:0] r_ac_col [NRECT];
  logic [1:0]  r_ac_ctl [NRECT];

  state_t          r_state;
  logic [IDXW-1:0] r_cnt;
  logic            r_wr_ready;
  logic            r_busy;
  logic            r_frame_done;
  logic [9:0]      r_prev_y;
  logic [NRECT-1:0] r_hit;
  logic            r_vis;
  logic [11:0]     r_rgb;

  logic             w_vblank_start;
  logic             w_wr_fire;
  logic [NRECT-1:0] w_hit;
  logic [11:0]      w_sel;

  assign w_vblank_start = (y == VA) && (r_prev_y != VA);
  assign w_wr_fire      = wr_if.wr_valid && r_wr_ready && ({1'b0, wr_if.wr_idx} < NREC_W);

  assign wr_if.wr_ready   = r_wr_ready;
  assign wr_if.busy       = r_busy;
  assign wr_if.frame_done = r_frame_done;
  assign o_dbg_state      = r_state;
  assign RED              = r_rgb[11:8];
  assign GREEN            = r_rgb[7:4];
  assign BLUE             = r_rgb[3:0];

  // Previous row, used to make vblank start a single-cycle event
  always_ff @(posedge clk) begin
    if (reset) r_prev_y <= '0;
    else       r_prev_y <= y;
  end

  // Publish FSM: IDLE -> PEND on commit, PEND -> COPY at vblank start,
  // COPY walks entries 0..NRECT-1 then returns to IDLE with frame_done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wr_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_if.commit) begin
            r_state    <= S_PEND;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_PEND: begin
          if (w_vblank_start) begin
            r_state <= S_COPY;
            r_cnt   <= '0;
          end
        end
        S_COPY: begin
          if (r_cnt == LAST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_wr_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Shadow table writes; reserved fields and out-of-range indices are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NRECT; i++) begin
        r_sh_x0[i]  <= '0;
        r_sh_x1[i]  <= '0;
        r_sh_y0[i]  <= '0;
        r_sh_y1[i]  <= '0;
        r_sh_col[i] <= '0;
        r_sh_ctl[i] <= '0;
      end
    end else if (w_wr_fire) begin
      case (wr_if.wr_field)
        3'd0:    r_sh_x0[wr_if.wr_idx]  <= wr_if.wr_data[9:0];
        3'd1:    r_sh_x1[wr_if.wr_idx]  <= wr_if.wr_data[9:0];
        3'd2:    r_sh_y0[wr_if.wr_idx]  <= wr_if.wr_data[9:0];
        3'd3:    r_sh_y1[wr_if.wr_idx]  <= wr_if.wr_data[9:0];
        3'd4:    r_sh_col[wr_if.wr_idx] <= wr_if.wr_data;
        3'd5:    r_sh_ctl[wr_if.wr_idx] <= wr_if.wr_data[1:0];
        default: ;
      endcase
    end
  end

  // Active table: entry r_cnt is copied from the shadow on each COPY cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NRECT; i++) begin
        r_ac_x0[i]  <= '0;
        r_ac_x1[i]  <= '0;
        r_ac_y0[i]  <= '0;
        r_ac_y1[i]  <= '0;
        r_ac_col[i] <= '0;
        r_ac_ctl[i] <= '0;
      end
    end else if (r_state == S_COPY) begin
      r_ac_x0[r_cnt]  <= r_sh_x0[r_cnt];
      r_ac_x1[r_cnt]  <= r_sh_x1[r_cnt];
      r_ac_y0[r_cnt]  <= r_sh_y0[r_cnt];
      r_ac_y1[r_cnt]  <= r_sh_y1[r_cnt];
      r_ac_col[r_cnt] <= r_sh_col[r_cnt];
      r_ac_ctl[r_cnt] <= r_sh_ctl[r_cnt];
    end
  end

  // Strict-interior hit test per active entry (optionally reduced to outline)
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NRECT; i++) begin
      w_hit[i] = r_ac_ctl[i][0] &&
                 (r_ac_x0[i] < x) && (x < r_ac_x1[i]) &&
                 (r_ac_y0[i] < y) && (y < r_ac_y1[i]);
`ifdef RECT_OUTLINE_EN
      if (r_ac_ctl[i][1]) begin
        w_hit[i] = w_hit[i] &&
                   ((x == r_ac_x0[i] + 10'd1) || (x == r_ac_x1[i] - 10'd1) ||
                    (y == r_ac_y0[i] + 10'd1) || (y == r_ac_y1[i] - 10'd1));
      end
`endif
    end
  end

`ifndef RECT_OUTLINE_EN
  // The outline bit is kept in the table but has no effect in this build
  logic w_unused_outline;
  always_comb begin
    w_unused_outline = 1'b0;
    for (int i = 0; i < NRECT; i++) w_unused_outline = w_unused_outline ^ r_ac_ctl[i][1];
  end
`endif

  // Stage 1: register hit vector and visibility
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit <= '0;
      r_vis <= 1'b0;
    end else begin
      r_hit <= w_hit;
      r_vis <= (x < HA) && (y < VA);
    end
  end

  // Priority select: lowest index with a hit wins, else background
  always_comb begin
    w_sel = BG_RGB;
    for (int i = NRECT - 1; i >= 0; i--) begin
      if (r_hit[i]) w_sel = r_ac_col[i];
    end
  end

  // Stage 2: register the final pixel colour, black outside the visible area
  always_ff @(posedge clk) begin
    if (reset) r_rgb <= '0;
    else       r_rgb <= r_vis ? w_sel : 12'h000;
  end

endmodule

// File: tb/tb_rect_layer_ctrl.sv
// Self-checking bench for rect_layer_ctrl: directed vectors, multi-cycle
// publish/commit sequences and randomized descriptors against a reference model.
module tb_rect_layer_ctrl;
  localparam int          NRECT = 4;
  localparam logic [11:0] BG    = 12'h000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic [3:0] red, green, blue;
  logic [1:0] unused_dbg_state;

  always #5 clk = ~clk;

  rect_layer_ctrl_if #(.IDXW(2)) wr_if ();

  rect_layer_ctrl #(
    .NRECT(NRECT), .IDXW(2), .H_ACTIVE(640), .V_ACTIVE(480), .BG_RGB(BG)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .wr_if(wr_if.slave),
    .RED(red), .GREEN(green), .BLUE(blue), .o_dbg_state(unused_dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] m_sh [NRECT][8];
  logic [11:0] m_ac [NRECT][8];
  bit          m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NRECT; i++)
      for (int f = 0; f < 8; f++) begin
        m_sh[i][f] = '0;
        m_ac[i][f] = '0;
      end
    m_pend = 0;
  endtask

  // Pixel colour from the rules: visible area, strict interior, lowest index wins
  function automatic logic [11:0] model_rgb(input int px, input int py);
    int x0, x1, y0, y1;
    bit hit;
    if (!(px < 640 && py < 480)) return 12'h000;
    for (int i = 0; i < NRECT; i++) begin
      x0 = int'(m_ac[i][0][9:0]); x1 = int'(m_ac[i][1][9:0]);
      y0 = int'(m_ac[i][2][9:0]); y1 = int'(m_ac[i][3][9:0]);
      hit = m_ac[i][5][0] && x0 < px && px < x1 && y0 < py && py < y1;
`ifdef RECT_OUTLINE_EN
      if (m_ac[i][5][1])
        hit = hit && (px == x0 + 1 || px == x1 - 1 || py == y0 + 1 || py == y1 - 1);
`endif
      if (hit) return m_ac[i][4];
    end
    return BG;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int idx, input int field, input logic [11:0] data, input bit do_commit);
    int t = 0;
    while (!wr_if.wr_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("wr_ready_timeout", 32'd0, 32'd1);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_idx   = 2'(idx);
    wr_if.wr_field = 3'(field);
    wr_if.wr_data  = data;
    wr_if.commit   = do_commit;
    tick();
    wr_if.wr_valid = 1'b0;
    wr_if.commit   = 1'b0;
    if (idx < NRECT && field < 6) m_sh[idx][field] = data;
    if (do_commit && !m_pend) m_pend = 1;
  endtask

  task automatic wr_rect(input int idx, input int x0, input int x1, input int y0,
                         input int y1, input logic [11:0] col, input logic [11:0] ctl);
    wr(idx, 0, 12'(x0), 0);
    wr(idx, 1, 12'(x1), 0);
    wr(idx, 2, 12'(y0), 0);
    wr(idx, 3, 12'(y1), 0);
    wr(idx, 4, col, 0);
    wr(idx, 5, ctl, 0);
  endtask

  task automatic commit_pulse();
    wr_if.commit = 1'b1;
    tick();
    wr_if.commit = 1'b0;
    if (!m_pend) m_pend = 1;
  endtask

  task automatic pix(input string name, input int px, input int py, input logic [11:0] exp);
    x = 10'(px);
    y = 10'(py);
    tick();
    tick();
    check(name, {20'h0, red, green, blue}, {20'h0, exp});
  endtask

  // Drive a vblank start with a commit pending and follow the copy to frame_done
  task automatic do_vblank(input bit pulse_commit);
    bit seen = 0;
    x = 10'd0;
    y = 10'd0;
    tick();
    y = 10'd480;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (wr_if.frame_done) begin
        seen = 1;
        check("busy_at_done", {31'h0, wr_if.busy}, 32'd0);
        check("ready_at_done", {31'h0, wr_if.wr_ready}, 32'd1);
      end else begin
        check("busy_in_copy", {31'h0, wr_if.busy}, 32'd1);
        check("ready_in_copy", {31'h0, wr_if.wr_ready}, 32'd0);
      end
      wr_if.commit = (pulse_commit && c == 2);
    end
    wr_if.commit = 1'b0;
    check("frame_done_seen", {31'h0, seen}, 32'd1);
    tick();
    check("frame_done_pulse", {31'h0, wr_if.frame_done}, 32'd0);
    if (seen) begin
      m_ac = m_sh;
      m_pend = 0;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          px;
    int          py;
    logic [11:0] exp;
  } vec_t;

  vec_t tv [12];

  initial begin
    tv[0]  = '{250, 200, 12'hF00};  // overlap: e0 wins
    tv[1]  = '{350, 200, 12'h0F0};  // e1 only
    tv[2]  = '{1,   100, 12'h000};  // x == x0 excluded
    tv[3]  = '{2,   100, 12'hF00};
    tv[4]  = '{298, 100, 12'hF00};
    tv[5]  = '{299, 100, 12'h000};  // x == x1 excluded
    tv[6]  = '{299, 200, 12'h0F0};
    tv[7]  = '{400, 200, 12'h000};  // x == x1 of e1
    tv[8]  = '{640, 200, 12'h000};  // horizontal blank
    tv[9]  = '{250, 480, 12'h000};  // vertical blank
    tv[10] = '{100, 299, 12'h000};  // y == y1
    tv[11] = '{100, 298, 12'hF00};

    reset = 1'b1;
    x = '0; y = '0;
    wr_if.wr_valid = 1'b0; wr_if.wr_idx = '0; wr_if.wr_field = '0;
    wr_if.wr_data = '0; wr_if.commit = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_wr_ready", {31'h0, wr_if.wr_ready}, 32'd1);
    check("rst_busy", {31'h0, wr_if.busy}, 32'd0);
    check("rst_frame_done", {31'h0, wr_if.frame_done}, 32'd0);
    check("rst_rgb", {20'h0, red, green, blue}, 32'd0);
    pix("bg_100_100", 100, 100, 12'h000);

    // First publish
    wr_rect(0, 1, 299, 1, 299, 12'hF00, 12'h001);
    commit_pulse();
    check("busy_after_commit", {31'h0, wr_if.busy}, 32'd1);
    check("ready_after_commit", {31'h0, wr_if.wr_ready}, 32'd0);
    do_vblank(0);
    pix("e0_fill", 100, 100, 12'hF00);

    // Second entry and vector table
    wr_rect(1, 200, 400, 150, 350, 12'h0F0, 12'h001);
    commit_pulse();
    do_vblank(0);
    for (int i = 0; i < 12; i++) pix($sformatf("vec%0d", i), tv[i].px, tv[i].py, tv[i].exp);

    // Shadow write without commit leaves the active frame alone
    wr(0, 4, 12'h00F, 0);
    pix("no_tear", 100, 100, 12'hF00);
    commit_pulse();
    do_vblank(0);
    pix("after_commit_00f", 100, 100, 12'h00F);

    // Reserved fields are discarded
    wr(0, 6, 12'hFFF, 0);
    wr(0, 7, 12'h000, 0);
    commit_pulse();
    do_vblank(0);
    pix("reserved_ignored", 100, 100, 12'h00F);

    // Write held through PEND/COPY, commit pulsed during COPY
    commit_pulse();
    wr_if.wr_valid = 1'b1; wr_if.wr_idx = 2'd1; wr_if.wr_field = 3'd4; wr_if.wr_data = 12'hABC;
    tick();
    check("ready_in_pend", {31'h0, wr_if.wr_ready}, 32'd0);
    do_vblank(1);
    wr_if.wr_valid = 1'b0;
    m_sh[1][4] = 12'hABC;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("commit_in_copy_ignored", {31'h0, wr_if.busy}, 32'd0);
    end
    pix("held_not_yet_active", 350, 200, 12'h0F0);
    commit_pulse();
    do_vblank(0);
    pix("held_write_landed", 350, 200, 12'hABC);

    // Commit during vblank waits for the next frame's vblank start
    wr(0, 4, 12'h0FF, 0);
    x = 10'd0; y = 10'd480;
    tick();
    tick();
    commit_pulse();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pend_wait_busy", {31'h0, wr_if.busy}, 32'd1);
      check("pend_wait_no_done", {31'h0, wr_if.frame_done}, 32'd0);
    end
    do_vblank(0);
    pix("late_commit", 100, 100, 12'h0FF);

    // Write and commit in the same cycle
    wr(0, 4, 12'hF0F, 1);
    do_vblank(0);
    pix("wr_commit_same", 100, 100, 12'hF0F);

    // Outline configuration
    wr_rect(0, 10, 20, 10, 20, 12'hC3C, 12'h003);
    commit_pulse();
    do_vblank(0);
    pix("outline_edge", 11, 15, 12'hC3C);
`ifdef RECT_OUTLINE_EN
    pix("outline_inner", 15, 15, BG);
`else
    pix("outline_inner", 15, 15, 12'hC3C);
`endif
    pix("outline_x1", 19, 15, 12'hC3C);
    pix("outline_y1", 15, 19, 12'hC3C);

    // Randomized descriptors against the model
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 8; w++) begin
        int f = $urandom_range(0, 7);
        logic [11:0] d;
        if (f < 4)       d = 12'($urandom_range(0, 700));
        else if (f == 5) d = 12'($urandom_range(0, 3));
        else             d = 12'($urandom);
        wr($urandom_range(0, 3), f, d, 0);
      end
      commit_pulse();
      do_vblank(0);
      for (int w = 0; w < 3; w++) wr($urandom_range(0, 3), $urandom_range(0, 4), 12'($urandom_range(0, 700)), 0);
      for (int p = 0; p < 16; p++) begin
        int px = $urandom_range(0, 700);
        int py = $urandom_range(0, 520);
        pix($sformatf("rand_r%0d_p%0d", r, p), px, py, model_rgb(px, py));
      end
    end

    // Reset in the middle of a copy discards everything
    wr(0, 4, 12'h111, 0);
    commit_pulse();
    x = 10'd0; y = 10'd0;
    tick();
    y = 10'd480;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("midcopy_rst_busy", {31'h0, wr_if.busy}, 32'd0);
    check("midcopy_rst_ready", {31'h0, wr_if.wr_ready}, 32'd1);
    check("midcopy_rst_done", {31'h0, wr_if.frame_done}, 32'd0);
    pix("midcopy_rst_pix", 100, 100, model_rgb(100, 100));
    commit_pulse();
    do_vblank(0);
    pix("midcopy_rst_clean", 100, 100, 12'h000);
    pix("midcopy_rst_clean2", 15, 15, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
